// File: rtl/puzzle3_bank_sched.sv
// rtl/puzzle3_bank_sched.sv - byte-stream line buffer and digit-burst sequencer for the bank-maximum datapath
module puzzle3_bank_sched #(
   parameter int MAX_BANK_LEN = 128,
   parameter int LEN_W        = $clog2(MAX_BANK_LEN + 1),
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_byte,
   input  logic             in_last,
   output logic [3:0]       dig_data,
   output logic             dig_wr_en,
   output logic             dig_bank_end,
   output logic             dp_en,
   output logic [CNT_W-1:0] bank_count,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int AW = (MAX_BANK_LEN > 1) ? $clog2(MAX_BANK_LEN) : 1;
   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_BANK_LEN);

   localparam logic [2:0] S_FILL   = 3'd0;
   localparam logic [2:0] S_DRAIN  = 3'd1;
   localparam logic [2:0] S_COMMIT = 3'd2;
   localparam logic [2:0] S_DONE   = 3'd3;
   localparam logic [2:0] S_ERR    = 3'd4;

   logic [3:0]       mem_q [MAX_BANK_LEN];
   logic [2:0]       state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d, len_n;
   logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             eof_q, eof_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             in_ready_q, dig_wr_en_q, dig_bank_end_q, dp_en_q, busy_q, done_q, err_q;
   logic [3:0]       dig_data_q, dig_data_d;
   logic             xfer, is_digit, is_lf, is_cr, bad, store;

   assign xfer     = in_valid & in_ready_q;
   assign is_digit = (in_byte >= 8'h30) && (in_byte <= 8'h39);
   assign is_lf    = (in_byte == 8'h0A);
   assign is_cr    = (in_byte == 8'h0D);

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      rd_ptr_d = rd_ptr_q;
      eof_d    = eof_q;
      count_d  = count_q;
      len_n    = len_q;
      bad      = 1'b0;
      store    = 1'b0;
      case (state_q)
         S_FILL: begin
            if (xfer) begin
               if (is_digit) begin
                  if (len_q == MAX_L) begin
                     bad = 1'b1;
                  end else begin
                     store = 1'b1;
                     len_n = len_q + LEN_W'(1);
                  end
               end else if (!is_cr && !is_lf) begin
                  bad = 1'b1;
               end
               if (in_last) eof_d = 1'b1;
               len_d = len_n;
               // in_last closes the current line exactly as a newline would
               if (bad) begin
                  state_d = S_ERR;
               end else if (is_lf || in_last) begin
                  if (len_n == '0)
                     state_d = in_last ? S_DONE : S_FILL;
                  else if (len_n == LEN_W'(1))
                     state_d = S_ERR;
                  else
                     state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (rd_ptr_q == len_q - LEN_W'(1)) begin
               state_d  = S_COMMIT;
               rd_ptr_d = '0;
            end else begin
               rd_ptr_d = rd_ptr_q + LEN_W'(1);
            end
         end
         S_COMMIT: begin
            count_d  = count_q + CNT_W'(1);
            len_d    = '0;
            rd_ptr_d = '0;
            state_d  = eof_q ? S_DONE : S_FILL;
         end
         default: state_d = state_q;
      endcase
   end

   // Outputs are decoded from the next state so they register alongside it
   always_comb begin
      dig_data_d = 4'd0;
      if (state_d == S_DRAIN) dig_data_d = mem_q[rd_ptr_d[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (store) mem_q[len_q[AW-1:0]] <= in_byte[3:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_FILL;
         len_q          <= '0;
         rd_ptr_q       <= '0;
         eof_q          <= 1'b0;
         count_q        <= '0;
         in_ready_q     <= 1'b1;
         dig_data_q     <= 4'd0;
         dig_wr_en_q    <= 1'b0;
         dig_bank_end_q <= 1'b0;
         dp_en_q        <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         len_q          <= len_d;
         rd_ptr_q       <= rd_ptr_d;
         eof_q          <= eof_d;
         count_q        <= count_d;
         in_ready_q     <= (state_d == S_FILL);
         dig_data_q     <= dig_data_d;
         dig_wr_en_q    <= (state_d == S_DRAIN);
         dig_bank_end_q <= (state_d == S_DRAIN) && (rd_ptr_d == len_d - LEN_W'(1));
         dp_en_q        <= (state_d == S_DRAIN) || (state_d == S_COMMIT);
         busy_q         <= (state_d == S_DRAIN) || (state_d == S_COMMIT);
         done_q         <= (state_d == S_DONE);
         err_q          <= (state_d == S_ERR);
      end
   end

   assign in_ready     = in_ready_q;
   assign dig_data     = dig_data_q;
   assign dig_wr_en    = dig_wr_en_q;
   assign dig_bank_end = dig_bank_end_q;
   assign dp_en        = dp_en_q;
   assign bank_count   = count_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;

endmodule

// File: doc/puzzle3_bank_sched.md
Name: puzzle3_bank_sched

Overview:
- Input-side sequencer for the day-3 bank-maximum accumulator datapath.
- Accepts the raw ASCII puzzle file as a byte stream with a valid/ready handshake, and validates and buffers one bank (line) of digits.
- Replays each buffered bank to the datapath as a gap-free digit burst, followed by exactly one commit cycle.
- Drives a datapath clock-enable so the datapath's accumulator advances only during burst and commit cycles. It reports bank count, completion and format errors.

Parameters:
- MAX_BANK_LEN, 128, maximum digits per bank; this sets the line-buffer depth.
- LEN_W, $clog2(MAX_BANK_LEN+1), width of the length and pointer counters.
- CNT_W, 16, width of bank_count.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_byte is valid this cycle.
- in_ready  out  1  the block accepts in_byte this cycle; a transfer occurs when in_valid & in_ready.
- in_byte  in  8  ASCII file byte.
- in_last  in  1  marks the final byte of the file; qualified by a transfer.
- dig_data  out  4  digit value to the datapath.
- dig_wr_en  out  1  digit strobe; low marks the commit cycle.
- dig_bank_end  out  1  high with the last digit of a bank.
- dp_en  out  1  datapath clock-enable; high only during DRAIN and COMMIT.
- bank_count  out  CNT_W  number of banks committed; wraps modulo 2^CNT_W.
- busy  out  1  high in DRAIN and COMMIT.
- done  out  1  sticky; the file has been fully processed.
- err  out  1  sticky; a format error or overflow occurred.

Behaviour:
- Reset (rst high at a clock edge):
  - state=FILL, len=0, rd_ptr=0, eof flag cleared.
  - Outputs: bank_count=0, done=0, err=0, dig_wr_en=0, dig_bank_end=0, dig_data=0, dp_en=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-burst aborts the burst with no commit; buffer contents are discarded.
- FILL state (in_ready=1, dp_en=0). Action per accepted byte:
  - 0x30-0x39: store byte-0x30 at buf[len], then len++. If len==MAX_BANK_LEN before the store, go to ERR instead.
  - 0x0D: ignored.
  - 0x0A with len>=2: go to DRAIN next cycle.
  - 0x0A with len==0: empty line, ignored.
  - 0x0A with len==1: go to ERR.
  - Any other byte: go to ERR.
- in_last handling:
  - Sets the eof flag.
  - If in_last accompanies a digit, that digit is stored and the bank ends as if a newline followed. Same len rules apply: len>=2 goes to DRAIN; len==1 goes to ERR.
  - If len==0 after the in_last byte is processed, go directly to DONE.
- DRAIN state (in_ready=0):
  - One digit per cycle for rd_ptr=0..len-1: dig_data=buf[rd_ptr], dig_wr_en=1, dp_en=1.
  - dig_bank_end=1 only when rd_ptr==len-1. No bubbles inside a burst.
- COMMIT state: exactly one cycle with dig_wr_en=0, dig_bank_end=0, dp_en=1.
  - bank_count increments.
  - len and rd_ptr clear.
  - Next state: DONE if eof, else FILL.
- DONE state: done=1, in_ready=0, dp_en=0. Held until rst.
- ERR state: err=1, in_ready=0, dp_en=0, done=0. No further commits. Held until rst.
- Outputs are registered. Timing:
  - First dig_wr_en is asserted in the cycle after the terminating byte is accepted.
  - A bank of N digits occupies N+1 dp_en cycles.
  - Back-to-back banks are separated by at least one FILL cycle per input byte.
- dp_en is never high outside DRAIN and COMMIT, so the datapath sees no accumulation during idle or fill.

Test Plan:
- Feed "987654321111111\n" with in_last on '\n'.
  - 15 consecutive dig_wr_en cycles with dig_data 9,8,7,...,1; dig_bank_end only on the 15th.
  - One commit cycle with dp_en=1, dig_wr_en=0; then bank_count=1 and done=1.
  - Paired datapath sum=98.
- Feed "987654321111111\n811111111111119\n234234234234278\n818181911112111" with in_last on the final '1'.
  - Four bursts, bank_count=4, done=1.
  - Paired datapath sum=357.
- Feed "12\r\n\n34\n" with in_valid toggling every other cycle.
  - CR and the empty line are ignored; two bursts of length 2.
  - bank_count=2; dp_en=0 on every fill cycle.
- Feed "5\n".
  - err=1 after the newline; no dig_wr_en ever asserted; in_ready=0 thereafter.
- Feed MAX_BANK_LEN+1 digits, and separately "12a".
  - err=1 on the offending byte; bank_count unchanged at 0.
- Assert rst during the 3rd digit of a 10-digit burst.
  - Next cycle: all outputs at reset values, bank_count=0, in_ready=1.
  - A following "77\n" yields one clean 2-digit burst and bank_count=1.
